// File: rtl/interrupt_controller.sv
// Eight-line edge-triggered interrupt controller: latch, mask, prioritise and hand-shake with the trap microroutine.
// Optional IRQ_SYNC_EN inserts a two-flop synchroniser on every irq_in bit ahead of the edge detector.
module interrupt_controller #(
    parameter logic [7:0] VECTOR_BASE   = 8'h00,
    parameter logic [7:0] VECTOR_STRIDE = 8'h02
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] irq_in,
    input  logic       irq_en,
    input  logic [7:0] z_bus,
    input  logic       ctrl_irq_masks_wrt,
    input  logic       ctrl_int_ack,
    input  logic       ctrl_clear_all_ints,
    output logic       int_pending,
    output logic [7:0] int_vector,
    output logic [7:0] irq_masks,
    output logic [7:0] irq_status,
    output logic       ack_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] irq_src;
    logic [7:0] irq_samp;
    logic [7:0] irq_prev;
    logic [2:0] prime_cnt;
    logic       detect_en;
    logic [7:0] rise;
    logic [7:0] qualified;
    logic       pend_raw;
    logic [2:0] sel_idx;
    logic [7:0] sel_vector;
    logic       ack_accept;
    logic [7:0] status_next;
    logic [7:0] hold_vector;

`ifdef IRQ_SYNC_EN
    localparam logic [2:0] PRIME_CYCLES = 3'd4;
    logic [7:0] sync1;
    logic [7:0] sync2;

    always_ff @(posedge clk) begin
        if (arst) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign irq_src = sync2;
`else
    localparam logic [2:0] PRIME_CYCLES = 3'd2;
    assign irq_src = irq_in;
`endif

    // Edges are suppressed until the sample chain has refilled after reset,
    // so a line already high at reset release never looks like a 0->1 transition.
    always_ff @(posedge clk) begin
        if (arst) begin
            irq_samp  <= 8'h00;
            irq_prev  <= 8'h00;
            prime_cnt <= 3'd0;
        end else begin
            irq_samp <= irq_src;
            irq_prev <= irq_samp;
            if (prime_cnt < PRIME_CYCLES) begin
                prime_cnt <= prime_cnt + 3'd1;
            end
        end
    end

    assign detect_en = (prime_cnt >= PRIME_CYCLES);
    assign rise      = irq_samp & ~irq_prev & {8{detect_en}};
    assign qualified = irq_status & irq_masks;
    assign pend_raw  = irq_en & (|qualified);

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (qualified[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    assign sel_vector = VECTOR_BASE + ({5'd0, sel_idx} * VECTOR_STRIDE);
    assign ack_accept = (state == ST_REQ) && ctrl_int_ack && pend_raw;

    // Priority of simultaneous events: ack clear, then new edges, then clear-all overrides both.
    always_comb begin
        status_next = irq_status;
        if (ack_accept) begin
            status_next[sel_idx] = 1'b0;
        end
        status_next = status_next | rise;
        if (ctrl_clear_all_ints) begin
            status_next = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state       <= ST_IDLE;
            irq_status  <= 8'h00;
            irq_masks   <= 8'h00;
            hold_vector <= 8'h00;
        end else begin
            state      <= state_next;
            irq_status <= status_next;
            if (ctrl_irq_masks_wrt) begin
                irq_masks <= z_bus;
            end
            if (ack_accept) begin
                hold_vector <= sel_vector;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pend_raw) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_accept) begin
                    state_next = ST_ACK;
                end else if (!pend_raw) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_next = pend_raw ? ST_REQ : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // During ACK the sequencer sees the held vector and no new pending request.
    always_comb begin
        ack_valid   = (state == ST_ACK);
        int_pending = pend_raw && (state != ST_ACK);
        int_vector  = 8'h00;
        if (state == ST_ACK) begin
            int_vector = hold_vector;
        end else if (pend_raw) begin
            int_vector = sel_vector;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboarded bench for interrupt_controller in its default build (IRQ_SYNC_EN undefined).
// Each step drives one cycle of inputs and queues the outputs expected after the next rising edge.
module tb_interrupt_controller;

    logic       clk;
    logic       arst;
    logic [7:0] irq_in;
    logic       irq_en;
    logic [7:0] z_bus;
    logic       ctrl_irq_masks_wrt;
    logic       ctrl_int_ack;
    logic       ctrl_clear_all_ints;
    logic       int_pending;
    logic [7:0] int_vector;
    logic [7:0] irq_masks;
    logic [7:0] irq_status;
    logic       ack_valid;

    typedef struct {
        string      tag;
        logic       pend;
        logic [7:0] vec;
        logic [7:0] msk;
        logic [7:0] sts;
        logic       ackv;
    } exp_t;

    exp_t expQueue[$];
    int   checkCount = 0;
    int   passCount  = 0;

    interrupt_controller dut (
        .clk                 (clk),
        .arst                (arst),
        .irq_in              (irq_in),
        .irq_en              (irq_en),
        .z_bus               (z_bus),
        .ctrl_irq_masks_wrt  (ctrl_irq_masks_wrt),
        .ctrl_int_ack        (ctrl_int_ack),
        .ctrl_clear_all_ints (ctrl_clear_all_ints),
        .int_pending         (int_pending),
        .int_vector          (int_vector),
        .irq_masks           (irq_masks),
        .irq_status          (irq_status),
        .ack_valid           (ack_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle at the falling edge, then compare at the following falling edge.
    task automatic applyStimulus(
        input string      tag,
        input logic       rst,
        input logic [7:0] irq,
        input logic [7:0] z,
        input logic       wrt,
        input logic       ack,
        input logic       clr,
        input logic       e_pend,
        input logic [7:0] e_vec,
        input logic [7:0] e_msk,
        input logic [7:0] e_sts,
        input logic       e_ack
    );
        exp_t e;
        exp_t got;
        arst                = rst;
        irq_in              = irq;
        z_bus               = z;
        ctrl_irq_masks_wrt  = wrt;
        ctrl_int_ack        = ack;
        ctrl_clear_all_ints = clr;
        e.tag  = tag;
        e.pend = e_pend;
        e.vec  = e_vec;
        e.msk  = e_msk;
        e.sts  = e_sts;
        e.ackv = e_ack;
        expQueue.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = expQueue.pop_front();
        checkOutput($sformatf("%s.int_pending", got.tag), {7'd0, int_pending}, {7'd0, got.pend});
        checkOutput($sformatf("%s.int_vector", got.tag), int_vector, got.vec);
        checkOutput($sformatf("%s.irq_masks", got.tag), irq_masks, got.msk);
        checkOutput($sformatf("%s.irq_status", got.tag), irq_status, got.sts);
        checkOutput($sformatf("%s.ack_valid", got.tag), {7'd0, ack_valid}, {7'd0, got.ackv});
    endtask

    initial begin
        arst = 1'b1;
        irq_in = 8'h00;
        irq_en = 1'b1;
        z_bus = 8'h00;
        ctrl_irq_masks_wrt = 1'b0;
        ctrl_int_ack = 1'b0;
        ctrl_clear_all_ints = 1'b0;
        @(negedge clk);

        //            tag        rst irq    z      wrt  ack  clr  pend vec    msk    sts    ackv
        applyStimulus("rst0",    1, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);
        applyStimulus("rst1",    1, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);
        applyStimulus("idle1",   0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);
        applyStimulus("idle2",   0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);

        // Mask 0x05, pulse IRQ2
        applyStimulus("t1mask",  0, 8'h00, 8'h05, 1,   0,   0,   0,   8'h00, 8'h05, 8'h00, 0);
        applyStimulus("t1edge",  0, 8'h04, 8'h00, 0,   0,   0,   0,   8'h00, 8'h05, 8'h00, 0);
        applyStimulus("t1lat",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h04, 8'h05, 8'h04, 0);
        applyStimulus("t1req",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h04, 8'h05, 8'h04, 0);
        applyStimulus("t1ack",   0, 8'h00, 8'h00, 0,   1,   0,   0,   8'h04, 8'h05, 8'h00, 1);
        applyStimulus("t1idle",  0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'h05, 8'h00, 0);

        // Masked latch, then unmask
        applyStimulus("t2mask0", 0, 8'h00, 8'h00, 1,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);
        applyStimulus("t2edge",  0, 8'h02, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);
        applyStimulus("t2lat",   0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h02, 0);
        applyStimulus("t2unmsk", 0, 8'h00, 8'h02, 1,   0,   0,   1,   8'h02, 8'h02, 8'h02, 0);
        applyStimulus("t2req",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h02, 8'h02, 8'h02, 0);
        applyStimulus("t2ack",   0, 8'h00, 8'h00, 0,   1,   0,   0,   8'h02, 8'h02, 8'h00, 1);
        applyStimulus("t2idle",  0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'h02, 8'h00, 0);

        // IRQ5 + IRQ3, acks in IDLE and ACK are ignored
        applyStimulus("t3mask",  0, 8'h00, 8'hFF, 1,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);
        applyStimulus("t3edge",  0, 8'h28, 8'h00, 0,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);
        applyStimulus("t3lat",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h06, 8'hFF, 8'h28, 0);
        applyStimulus("t3ackIdl",0, 8'h00, 8'h00, 0,   1,   0,   1,   8'h06, 8'hFF, 8'h28, 0);
        applyStimulus("t3ack1",  0, 8'h00, 8'h00, 0,   1,   0,   0,   8'h06, 8'hFF, 8'h20, 1);
        applyStimulus("t3ackAck",0, 8'h00, 8'h00, 0,   1,   0,   1,   8'h0A, 8'hFF, 8'h20, 0);
        applyStimulus("t3ack2",  0, 8'h00, 8'h00, 0,   1,   0,   0,   8'h0A, 8'hFF, 8'h00, 1);
        applyStimulus("t3idle",  0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);

        // Ack IRQ0 while a new IRQ0 edge lands
        applyStimulus("t4edge",  0, 8'h01, 8'h00, 0,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);
        applyStimulus("t4lat",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h00, 8'hFF, 8'h01, 0);
        applyStimulus("t4req",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h00, 8'hFF, 8'h01, 0);
        applyStimulus("t4edge2", 0, 8'h01, 8'h00, 0,   0,   0,   1,   8'h00, 8'hFF, 8'h01, 0);
        applyStimulus("t4ackSet",0, 8'h00, 8'h00, 0,   1,   0,   0,   8'h00, 8'hFF, 8'h01, 1);
        applyStimulus("t4repend",0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h00, 8'hFF, 8'h01, 0);
        applyStimulus("t4ack",   0, 8'h00, 8'h00, 0,   1,   0,   0,   8'h00, 8'hFF, 8'h00, 1);
        applyStimulus("t4idle",  0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);

        // All latched, clear-all with a concurrent IRQ7 edge
        applyStimulus("t5edge",  0, 8'hFF, 8'h00, 0,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);
        applyStimulus("t5lat",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h00, 8'hFF, 8'hFF, 0);
        applyStimulus("t5req",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h00, 8'hFF, 8'hFF, 0);
        applyStimulus("t5edge7", 0, 8'h80, 8'h00, 0,   0,   0,   1,   8'h00, 8'hFF, 8'hFF, 0);
        applyStimulus("t5clr",   0, 8'h00, 8'h00, 0,   0,   1,   0,   8'h00, 8'hFF, 8'h00, 0);
        applyStimulus("t5after", 0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);

        // Clear-all together with ack still enters ACK with the pre-clear vector
        applyStimulus("t6edge",  0, 8'h10, 8'h00, 0,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);
        applyStimulus("t6lat",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h08, 8'hFF, 8'h10, 0);
        applyStimulus("t6req",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h08, 8'hFF, 8'h10, 0);
        applyStimulus("t6ackClr",0, 8'h00, 8'h00, 0,   1,   1,   0,   8'h08, 8'hFF, 8'h00, 1);
        applyStimulus("t6idle",  0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);

        // Mask write with ack selects using the old mask
        applyStimulus("t7edge",  0, 8'h0C, 8'h00, 0,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);
        applyStimulus("t7lat",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h04, 8'hFF, 8'h0C, 0);
        applyStimulus("t7req",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h04, 8'hFF, 8'h0C, 0);
        applyStimulus("t7ackWr", 0, 8'h00, 8'h08, 1,   1,   0,   0,   8'h04, 8'h08, 8'h08, 1);
        applyStimulus("t7req2",  0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h06, 8'h08, 8'h08, 0);
        applyStimulus("t7ack2",  0, 8'h00, 8'h00, 0,   1,   0,   0,   8'h06, 8'h08, 8'h00, 1);
        applyStimulus("t7idle",  0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'h08, 8'h00, 0);

        // Reset in ACK with status 0x10, irq_in held high through release
        applyStimulus("t8mask",  0, 8'h00, 8'hFF, 1,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);
        applyStimulus("t8edge",  0, 8'h18, 8'h00, 0,   0,   0,   0,   8'h00, 8'hFF, 8'h00, 0);
        applyStimulus("t8lat",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h06, 8'hFF, 8'h18, 0);
        applyStimulus("t8req",   0, 8'h00, 8'h00, 0,   0,   0,   1,   8'h06, 8'hFF, 8'h18, 0);
        applyStimulus("t8ack",   0, 8'h00, 8'h00, 0,   1,   0,   0,   8'h06, 8'hFF, 8'h10, 1);
        applyStimulus("t8rst",   1, 8'hFF, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);
        applyStimulus("t8rel1",  0, 8'hFF, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);
        applyStimulus("t8rel2",  0, 8'hFF, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);
        applyStimulus("t8rel3",  0, 8'hFF, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);
        applyStimulus("t8low",   0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);
        applyStimulus("t8done",  0, 8'h00, 8'h00, 0,   0,   0,   0,   8'h00, 8'h00, 8'h00, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
